// File: rtl/lcd_stream_pkg.sv
// Shared types and constants for the LCD frame streamer: FSM states, panel commands,
// frame geometry and the byte builders used by the command and pixel paths.
package lcd_stream_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_RWAIT,
    S_INIT,
    S_WIN,
    S_PIX,
    S_GAP
  } state_t;

  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] COLMOD  = 8'h3A;
  localparam logic [7:0] DISPON  = 8'h29;
  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] PASET   = 8'h2B;
  localparam logic [7:0] RAMWR   = 8'h2C;

  localparam int FB_W = 128;
  localparam int FB_H = 128;

  localparam logic [3:0] INIT_LAST = 4'd4;
  localparam logic [3:0] WIN_LAST  = 4'd6;

  // 3-bit RGB stored in the buffer, widened to the panel's RGB332 layout
  function automatic logic [7:0] rgb3_to_332(input logic [2:0] c);
    return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
  endfunction

  // {cd, byte} for each init step
  function automatic logic [8:0] init_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return {1'b0, SWRESET};
      4'd1:    return {1'b0, SLPOUT};
      4'd2:    return {1'b0, COLMOD};
      4'd3:    return {1'b1, 8'h02};
      default: return {1'b0, DISPON};
    endcase
  endfunction

  // {cd, byte} for each window / RAM-write step; the window covers the full buffer
  function automatic logic [8:0] win_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return {1'b0, CASET};
      4'd1:    return {1'b1, 8'h00};
      4'd2:    return {1'b1, 8'(FB_W - 1)};
      4'd3:    return {1'b0, PASET};
      4'd4:    return {1'b1, 8'h00};
      4'd5:    return {1'b1, 8'(FB_H - 1)};
      default: return {1'b0, RAMWR};
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// LCD byte strobe unit: WR low WR_LOW cycles then high WR_HIGH cycles, CD/D held throughout.
// Bus pins change the cycle after a start is taken; a start is taken when idle or in the done cycle.
module lcd_bus_writer #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_cd,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_wr,
  output logic       o_cd,
  output logic [7:0] o_d
);

  localparam logic [3:0] LOW_LAST  = 4'(WR_LOW - 1);
  localparam logic [3:0] HIGH_LAST = 4'(WR_HIGH - 1);

  logic       r_busy;
  logic       r_wr;
  logic       r_cd;
  logic [7:0] r_d;
  logic [3:0] r_cnt;
  logic       w_last;
  logic       w_take;

  assign w_last = r_busy && r_wr && (r_cnt == HIGH_LAST);
  assign w_take = i_start && (!r_busy || w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_wr   <= 1'b1;
      r_cd   <= 1'b0;
      r_d    <= 8'h00;
      r_cnt  <= 4'd0;
    end else if (w_take) begin
      r_busy <= 1'b1;
      r_wr   <= 1'b0;
      r_cd   <= i_cd;
      r_d    <= i_data;
      r_cnt  <= 4'd0;
    end else if (r_busy) begin
      if (!r_wr) begin
        if (r_cnt == LOW_LAST) begin
          r_wr  <= 1'b1;
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_wr   = r_wr;
  assign o_cd   = r_cd;
  assign o_d    = r_d;

endmodule

// File: rtl/lcd_frame_streamer.sv
// Pixel-write frame buffer scanned continuously onto an 8-bit LCD bus, with panel reset/init.
// Writes land every cycle with no stall; bus bytes run back to back, paced only by the strobe unit.
module lcd_frame_streamer
  import lcd_stream_pkg::*;
#(
  parameter int RST_HOLD  = 1024,
  parameter int RST_WAIT  = 4096,
  parameter int WR_LOW    = 2,
  parameter int WR_HIGH   = 2,
  parameter int FRAME_GAP = 0
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [13:0] VRAM_ADDR,
  input  logic [3:0]  VRAM_DATA,
  input  logic        VRAM_WE,
  output logic        LCD_CS0,
  output logic        LCD_CD,
  output logic        LCD_WR,
  output logic        LCD_RSTB,
  output logic [7:0]  LCD_D,
  output logic        FRAME_DONE
);

  localparam int DLY_A   = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
  localparam int DLY_MAX = (DLY_A > FRAME_GAP) ? DLY_A : FRAME_GAP;
  localparam int DW      = $clog2(DLY_MAX + 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(RST_HOLD - 1);
  localparam logic [DW-1:0] WAIT_LAST = DW'(RST_WAIT - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [13:0]   PIX_LAST  = 14'(FB_W * FB_H - 1);

  state_t        r_state;
  logic [DW-1:0] r_dly;
  logic [3:0]    r_idx;
  logic [13:0]   r_pix;
  logic          r_last;
  logic          r_rstb;
  logic          r_cs0;
  logic          r_frame_done;
  logic [2:0]    r_mem [0:FB_W*FB_H-1];
  logic [2:0]    r_rd_dat;

  logic          w_start;
  logic [3:0]    w_idx;
  logic          w_cd;
  logic [7:0]    w_data;
  logic          w_busy;
  logic          w_done;
  logic          w_go;
  logic          w_frame_end;
  logic          w_unused_rsvd;

  assign w_unused_rsvd = VRAM_DATA[3];

  // The scan address is read every cycle, so data is ready a cycle before each byte is taken
  always_ff @(posedge CLK) begin
    if (VRAM_WE) r_mem[VRAM_ADDR] <= VRAM_DATA[2:0];
    r_rd_dat <= r_mem[r_pix];
  end

  always_comb begin
    w_start = 1'b0;
    w_idx   = r_idx;
    case (r_state)
      S_RWAIT: begin
        w_start = (r_dly == WAIT_LAST);
        w_idx   = 4'd0;
      end
      S_INIT, S_WIN: w_start = 1'b1;
      S_PIX: begin
        w_start = !r_last || ((FRAME_GAP == 0) && w_done);
        w_idx   = 4'd0;
      end
      S_GAP: begin
        w_start = (r_dly == GAP_LAST);
        w_idx   = 4'd0;
      end
      default: w_start = 1'b0;
    endcase
  end

  // Pixel bytes come from the buffer; once the last pixel is taken, the next byte is CASET
  always_comb begin
    w_cd   = 1'b1;
    w_data = rgb3_to_332(r_rd_dat);
    if (r_state == S_RWAIT || r_state == S_INIT) begin
      {w_cd, w_data} = init_byte(w_idx);
    end else if (r_state != S_PIX || r_last) begin
      {w_cd, w_data} = win_byte(w_idx);
    end
  end

  assign w_go        = w_start && (!w_busy || w_done);
  assign w_frame_end = (r_state == S_PIX) && r_last && w_done;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state      <= S_RST;
      r_dly        <= '0;
      r_idx        <= 4'd0;
      r_pix        <= 14'd0;
      r_last       <= 1'b0;
      r_rstb       <= 1'b0;
      r_cs0        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_go) r_cs0 <= 1'b0;
      case (r_state)
        S_RST: begin
          if (r_dly == HOLD_LAST) begin
            r_dly   <= '0;
            r_rstb  <= 1'b1;
            r_state <= S_RWAIT;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        S_RWAIT: begin
          if (w_go) begin
            r_dly   <= '0;
            r_idx   <= 4'd1;
            r_state <= S_INIT;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        S_INIT: begin
          if (w_go) begin
            if (r_idx == INIT_LAST) begin
              r_idx   <= 4'd0;
              r_state <= S_WIN;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_WIN: begin
          if (w_go) begin
            if (r_idx == WIN_LAST) begin
              r_idx   <= 4'd0;
              r_state <= S_PIX;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_PIX: begin
          if (w_frame_end) begin
            r_last <= 1'b0;
            r_pix  <= 14'd0;
            if (FRAME_GAP == 0) begin
              r_idx   <= 4'd1;
              r_state <= S_WIN;
            end else begin
              r_dly   <= '0;
              r_state <= S_GAP;
            end
          end else if (w_go) begin
            if (r_pix == PIX_LAST) r_last <= 1'b1;
            else                   r_pix  <= r_pix + 14'd1;
          end
        end
        S_GAP: begin
          if (w_go) begin
            r_idx   <= 4'd1;
            r_state <= S_WIN;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  lcd_bus_writer #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_bus_writer (
    .i_clk   (CLK),
    .i_rst_n (RST_X),
    .i_start (w_start),
    .i_cd    (w_cd),
    .i_data  (w_data),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_wr    (LCD_WR),
    .o_cd    (LCD_CD),
    .o_d     (LCD_D)
  );

  assign LCD_CS0    = r_cs0;
  assign LCD_RSTB   = r_rstb;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench for lcd_frame_streamer: bus bytes captured at WR rising edges against a
// buffer model, plus reset, strobe, frame-gap and mid-frame reset timing.
module tb_lcd_frame_streamer;

  localparam int RST_HOLD  = 8;
  localparam int RST_WAIT  = 16;
  localparam int WR_LOW    = 3;
  localparam int WR_HIGH   = 1;
  localparam int FRAME_GAP = 5;
  localparam int NPIX      = 16384;
  localparam int TRIG      = 12 + NPIX + 7 + 100;

  logic        clk = 1'b0;
  logic        rst_x;
  logic [13:0] vram_addr;
  logic [3:0]  vram_data;
  logic        vram_we;
  logic        lcd_cs0, lcd_cd, lcd_wr, lcd_rstb, lcd_fd;
  logic [7:0]  lcd_d;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_rel    = 0;
  int          n_bytes  = 0;
  int          n_fd     = 0;
  logic [9:0]  sb [$];
  logic [2:0]  model [NPIX];
  logic [3:0]  raw   [NPIX];
  logic [8:0]  hdr   [12];

  always #5 clk = ~clk;

  lcd_frame_streamer #(
    .RST_HOLD  (RST_HOLD),
    .RST_WAIT  (RST_WAIT),
    .WR_LOW    (WR_LOW),
    .WR_HIGH   (WR_HIGH),
    .FRAME_GAP (FRAME_GAP)
  ) dut (
    .CLK        (clk),
    .RST_X      (rst_x),
    .VRAM_ADDR  (vram_addr),
    .VRAM_DATA  (vram_data),
    .VRAM_WE    (vram_we),
    .LCD_CS0    (lcd_cs0),
    .LCD_CD     (lcd_cd),
    .LCD_WR     (lcd_wr),
    .LCD_RSTB   (lcd_rstb),
    .LCD_D      (lcd_d),
    .FRAME_DONE (lcd_fd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    check_eq({pfx, "_cs0"},  lcd_cs0,  1);
    check_eq({pfx, "_cd"},   lcd_cd,   0);
    check_eq({pfx, "_wr"},   lcd_wr,   1);
    check_eq({pfx, "_rstb"}, lcd_rstb, 0);
    check_eq({pfx, "_d"},    lcd_d,    0);
    check_eq({pfx, "_fd"},   lcd_fd,   0);
  endtask

  function automatic logic [7:0] px332(input logic [2:0] c);
    return {c[2], c[2], c[2], c[1], c[1], c[1], c[0], c[0]};
  endfunction

  // Bus monitor: captures a byte on every WR rise and checks strobe timing around it
  initial begin : monitor
    logic       prev_wr, seen_fall, rstb_seen, cs_early, in_span, stable;
    logic       fd_pending, exp_fd, after_frame, span_cd;
    logic [7:0] span_d;
    logic [9:0] ent;
    int         lo_run, hi_run, t_rstb;
    prev_wr = 1'b1; seen_fall = 1'b0; rstb_seen = 1'b0; cs_early = 1'b0;
    in_span = 1'b0; stable = 1'b1; fd_pending = 1'b0; after_frame = 1'b0;
    span_cd = 1'b0; span_d = 8'h00; lo_run = 0; hi_run = 0; t_rstb = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_x) begin
        prev_wr = 1'b1; seen_fall = 1'b0; rstb_seen = 1'b0; cs_early = 1'b0;
        in_span = 1'b0; stable = 1'b1; fd_pending = 1'b0; after_frame = 1'b0;
        lo_run = 0; hi_run = 0;
      end else begin
        exp_fd = fd_pending;
        fd_pending = 1'b0;
        if (lcd_fd || exp_fd) check_eq("frame_done", lcd_fd, exp_fd);
        if (lcd_fd) n_fd++;
        if (!rstb_seen && lcd_rstb) begin
          rstb_seen = 1'b1;
          t_rstb = cyc;
          check_eq("rstb_hold", cyc - t_rel, RST_HOLD);
        end
        if (!seen_fall && !lcd_cs0 && lcd_wr) cs_early = 1'b1;
        if (prev_wr && !lcd_wr) begin
          if (!seen_fall) begin
            seen_fall = 1'b1;
            check_eq("wr_first", cyc - t_rstb, RST_WAIT);
            check_eq("cs0_early", cs_early, 0);
          end else begin
            check_eq("wr_high", hi_run, after_frame ? WR_HIGH + FRAME_GAP : WR_HIGH);
          end
          after_frame = 1'b0;
          lo_run = 0;
          in_span = 1'b1;
          stable = 1'b1;
          span_d = lcd_d;
          span_cd = lcd_cd;
        end
        if (in_span && (lcd_d !== span_d || lcd_cd !== span_cd)) stable = 1'b0;
        if (!prev_wr && lcd_wr && in_span) begin
          check_eq("wr_low", lo_run, WR_LOW);
          check_eq("span_stable", stable, 1);
          check_eq("cs0_low", lcd_cs0, 0);
          if (sb.size() == 0) begin
            check_eq("sb_extra", sb.size(), 1);
          end else begin
            ent = sb.pop_front();
            check_eq("sb_byte", {lcd_cd, lcd_d}, ent[8:0]);
            if (ent[9]) begin
              fd_pending = 1'b1;
              after_frame = 1'b1;
            end
          end
          n_bytes++;
          in_span = 1'b0;
          hi_run = 0;
        end
        if (lcd_wr) hi_run++;
        else        lo_run++;
        prev_wr = lcd_wr;
      end
    end
  end

  initial begin : driver
    int budget;
    hdr = '{9'h001, 9'h011, 9'h03A, 9'h102, 9'h029, 9'h02A,
            9'h100, 9'h17F, 9'h02B, 9'h100, 9'h17F, 9'h02C};
    rst_x = 1'b1; vram_we = 1'b0; vram_addr = 14'd0; vram_data = 4'd0;
    #2 rst_x = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    for (int a = 0; a < NPIX; a++) begin
      raw[a] = 4'($urandom_range(0, 15));
      model[a] = raw[a][2:0];
    end
    model[4229] = 3'b111;
    model[0]    = 3'b100;

    for (int i = 0; i < 12; i++) sb.push_back({1'b0, hdr[i]});
    for (int a = 0; a < NPIX; a++) sb.push_back({(a == NPIX - 1), 1'b1, px332(model[a])});
    for (int i = 5; i < 12; i++) sb.push_back({1'b0, hdr[i]});
    for (int a = 0; a < NPIX; a++) sb.push_back({(a == NPIX - 1), 1'b1, px332(model[a])});

    // Release, then write ahead of the scan: one write per cycle outruns one pixel per 4 cycles
    @(negedge clk);
    rst_x = 1'b1;
    t_rel = cyc;
    vram_we = 1'b1; vram_addr = {7'd33, 7'd5}; vram_data = 4'b0111;
    @(negedge clk);
    vram_addr = 14'd0; vram_data = 4'b1100;
    @(negedge clk);
    for (int a = 1; a < NPIX; a++) begin
      if (a != 4229) begin
        vram_addr = 14'(a);
        vram_data = raw[a];
        @(negedge clk);
      end
    end
    vram_we = 1'b0;

    budget = 90000;
    while (n_bytes < TRIG && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("tmo_frame2", n_bytes, TRIG);
    check_eq("fd_count", n_fd, 1);

    @(posedge clk);
    #3 rst_x = 1'b0;
    #1 chk_reset_outputs("mid");
    sb.delete();
    for (int i = 0; i < 12; i++) sb.push_back({1'b0, hdr[i]});
    for (int a = 0; a < 16; a++) sb.push_back({1'b0, 1'b1, px332(model[a])});
    repeat (3) @(negedge clk);
    rst_x = 1'b1;
    t_rel = cyc;

    budget = 2000;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("tmo_restart", sb.size(), 0);
    check_eq("fd_after_restart", n_fd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
